// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester add/subtract unit.
// The state enum, requester ids and flag bundle are kept here so the top and any checkers agree on encodings.
package alu_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_CNT_WIDTH = 16;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_add_arbiter_if.sv
// Request/response bundle between the issue logic and the shared adder.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are high; valid holds its payload until then.
interface alu_add_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req0_sub;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 req1_sub;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [WIDTH-1:0]     rsp_result;
    logic                 rsp_n;
    logic                 rsp_z;
    logic                 rsp_c;
    logic                 rsp_v;
    logic                 busy;
    logic [CNT_WIDTH-1:0] ops_done;
    state_t               state;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v,
        output busy, ops_done, state
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v,
        input  busy, ops_done, state
    );

endinterface

// File: rtl/alu_addsub_flags.sv
// Combinational WIDTH-bit add/subtract producing n/z/c/v.
// Subtraction is A + ~B + 1, so carry-out set means no borrow.
module alu_addsub_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    assign w_b_eff  = i_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
    assign o_result = w_sum[WIDTH-1:0];

    // Overflow uses the post-inversion operand so add and subtract share one rule.
    assign o_flags.n = w_sum[WIDTH-1];
    assign o_flags.z = (w_sum[WIDTH-1:0] == '0);
    assign o_flags.c = w_sum[WIDTH];
    assign o_flags.v = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_add_arbiter.sv
// Round-robin shares one add/sub unit between two requesters; IDLE grants, EXEC computes, RESP holds the tagged result.
// Operands are sampled only at the grant edge; ready is combinational and only ever high in IDLE.
module alu_add_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_add_arbiter_if.slave   bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_ptr;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sub;
    logic                 r_id;
    logic [WIDTH-1:0]     r_result;
    flags_t               r_flags;
    logic                 r_rsp_id;
    logic [CNT_WIDTH-1:0] r_ops_done;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_grant_any;
    logic                 w_rsp_hs;
    logic [WIDTH-1:0]     w_sum;
    flags_t               w_flags;

    always_comb begin
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // A lone request wins outright; a tie goes to the pointer side.
                if (bus.req0_valid && (!bus.req1_valid || r_ptr == ID_REQ0)) begin
                    w_grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    w_grant1 = 1'b1;
                end
                if (bus.req0_valid || bus.req1_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_grant_any = w_grant0 || w_grant1;
    assign w_rsp_hs    = (r_state == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_REQ0;
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
            r_id  <= ID_REQ0;
        end else if (w_grant_any) begin
            r_ptr <= w_grant1 ? ID_REQ0 : ID_REQ1;
            r_a   <= w_grant1 ? bus.req1_a   : bus.req0_a;
            r_b   <= w_grant1 ? bus.req1_b   : bus.req0_b;
            r_sub <= w_grant1 ? bus.req1_sub : bus.req0_sub;
            r_id  <= w_grant1 ? ID_REQ1 : ID_REQ0;
        end
    end

    alu_addsub_flags #(.WIDTH(WIDTH)) u_addsub (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sub    (r_sub),
        .o_result (w_sum),
        .o_flags  (w_flags)
    );

    // Response registers load only in EXEC, so they hold across RESP and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
            r_rsp_id <= ID_REQ0;
        end else if (r_state == ST_EXEC) begin
            r_result <= w_sum;
            r_flags  <= w_flags;
            r_rsp_id <= r_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_done <= '0;
        end else if (w_rsp_hs) begin
            r_ops_done <= r_ops_done + 1'b1;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_n      = r_flags.n;
    assign bus.rsp_z      = r_flags.z;
    assign bus.rsp_c      = r_flags.c;
    assign bus.rsp_v      = r_flags.v;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ops_done   = r_ops_done;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_alu_add_arbiter.sv
// Bench for alu_add_arbiter: directed vector table, round-robin, backpressure and reset sequences, then random ops.
// Expected responses are {id, result, n, z, c, v} packed into one word and queued in issue order.
module tb_alu_add_arbiter;
    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 16;
    localparam int W         = 1 + WIDTH + 4;

    logic clk;
    logic rst_n;

    alu_add_arbiter_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    alu_add_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]         exp_q[$];
    int                   n_pass;
    int                   n_total;
    logic                 exp_ptr;
    logic [CNT_WIDTH-1:0] exp_ops;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] result;
        logic [3:0]       nzcv;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model straight from arithmetic: wide unsigned sum for carry, wide signed sum for overflow.
    function automatic logic [W-1:0] model(input logic id, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic sub);
        longint unsigned ua, ub, ur;
        longint          sa, sb, sr;
        logic [WIDTH-1:0] res;
        logic n, z, c, v;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            c  = ur[32];
            sr = sa + sb;
        end
        res = ur[31:0];
        n = res[31];
        z = (res == 0);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {id, res, n, z, c, v};
    endfunction

    function automatic logic [W-1:0] dut_rsp();
        return {bus.rsp_id, bus.rsp_result, bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v};
    endfunction

    task automatic compare_rsp(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] g;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        g = dut_rsp();
        check({tag, "_id"},     64'(g[W-1]),      64'(e[W-1]));
        check({tag, "_result"}, 64'(g[W-2:4]),    64'(e[W-2:4]));
        check({tag, "_nzcv"},   64'(g[3:0]),      64'(e[3:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic id, input logic valid, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic sub);
        if (id) begin
            bus.req1_valid = valid; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
        end else begin
            bus.req0_valid = valid; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
        end
    endtask

    // One complete operation from a single requester; hold > 0 backpressures the response for that many cycles
    // while both requesters wave unrelated requests that must not be accepted.
    task automatic run_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input int hold, input logic [W-1:0] expect_rsp, input string tag);
        bit got;
        logic [W-1:0] first;
        exp_q.push_back(expect_rsp);
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        drive_req(id, 1'b1, a, b, sub);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check({tag, "_grant_timeout"}, 64'd0, 64'd1);
            drive_req(id, 1'b0, '0, '0, 1'b0);
            void'(exp_q.pop_back());
            return;
        end
        check({tag, "_other_ready"}, 64'(id ? bus.req0_ready : bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        drive_req(id, 1'b0, '0, '0, 1'b0);
        exp_ptr = ~id;
        check({tag, "_exec_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_exec_busy"},  64'(bus.busy),      64'd1);
        @(posedge clk); #1;
        check({tag, "_lat_valid"}, 64'(bus.rsp_valid), 64'd1);
        if (hold > 0) begin
            first = dut_rsp();
            drive_req(1'b0, 1'b1, $urandom, $urandom, 1'b0);
            drive_req(1'b1, 1'b1, $urandom, $urandom, 1'b1);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"},  64'(bus.rsp_valid), 64'd1);
                check({tag, "_hold_stable"}, 64'(dut_rsp()),     64'(first));
                check({tag, "_hold_ready"},  64'({bus.req0_ready, bus.req1_ready}), 64'd0);
                check({tag, "_hold_busy"},   64'(bus.busy),      64'd1);
                check({tag, "_hold_ops"},    64'(bus.ops_done),  64'(exp_ops));
            end
            drive_req(1'b0, 1'b0, '0, '0, 1'b0);
            drive_req(1'b1, 1'b0, '0, '0, 1'b0);
            bus.rsp_ready = 1'b1;
        end
        compare_rsp(tag);
        @(posedge clk); #1;
        exp_ops = exp_ops + 1'b1;
        check({tag, "_ops_done"},   64'(bus.ops_done),  64'(exp_ops));
        check({tag, "_post_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_post_busy"},  64'(bus.busy),      64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 1'b0;
        exp_ops = '0;
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rid, rsub;
        int               gcount, rcount, last_g;
        logic             gid;

        n_pass = 0;
        n_total = 0;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0);

        vecs[0] = '{1'b0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000};
        vecs[1] = '{1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 4'b1001};
        vecs[2] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0111};
        vecs[3] = '{1'b0, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 4'b0110};
        vecs[4] = '{1'b0, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 4'b1000};
        vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b0011};
        vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0110};
        vecs[7] = '{1'b0, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b1000};

        rst_n = 1'b0;
        #23;
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_busy",      64'(bus.busy),      64'd0);
        check("reset_ops_done",  64'(bus.ops_done),  64'd0);
        check("reset_rsp",       64'(dut_rsp()),     64'd0);
        check("reset_ready",     64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 1'b0;
        exp_ops = '0;

        // Both requesters valid continuously: grants alternate starting from req0, three cycles apart.
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
        drive_req(1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b0);
        gcount = 0; rcount = 0; last_g = 0;
        for (int cyc = 0; cyc < 60 && rcount < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (gcount == 4) begin
                drive_req(1'b0, 1'b0, '0, '0, 1'b0);
                drive_req(1'b1, 1'b0, '0, '0, 1'b0);
            end
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                gid = bus.req1_ready;
                check("rr_grant_id", 64'(gid), 64'(exp_ptr));
                check("rr_one_hot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
                if (gcount > 0) check("rr_spacing", 64'(cyc - last_g), 64'd3);
                last_g = cyc;
                exp_ptr = ~gid;
                exp_q.push_back(gid ? model(1'b1, 32'hFFFFFFFF, 32'd1, 1'b0)
                                    : model(1'b0, 32'd100, 32'd7, 1'b1));
                gcount++;
            end
            if (bus.rsp_valid) begin
                compare_rsp("rr");
                rcount++;
                exp_ops = exp_ops + 1'b1;
            end
        end
        check("rr_responses", 64'(rcount), 64'd4);
        @(posedge clk); #1;
        check("rr_ops_done", 64'(bus.ops_done), 64'(exp_ops));

        // Directed vectors against hand-computed expectations.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, (i == 2) ? 5 : 0,
                   {vecs[i].id, vecs[i].result, vecs[i].nzcv}, $sformatf("vec%0d", i));
        end

        // Reset during EXEC: everything clears at once and the in-flight op never responds.
        run_op(1'b1, 32'h40000000, 32'h40000000, 1'b0, 0,
               model(1'b1, 32'h40000000, 32'h40000000, 1'b0), "pre_rst");
        @(negedge clk);
        drive_req(1'b0, 1'b1, 32'h12345678, 32'h1, 1'b0);
        #1;
        check("mid_grant", 64'(bus.req0_ready), 64'd1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        check("mid_busy_exec", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_busy",  64'(bus.busy),      64'd0);
        check("mid_rst_ops",   64'(bus.ops_done),  64'd0);
        check("mid_rst_rsp",   64'(dut_rsp()),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 1'b0;
        exp_ops = '0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        run_op(1'b0, 32'd1, 32'd1, 1'b0, 0, {1'b0, 32'h00000002, 4'b0000}, "after_rst");

        // Random single-requester ops with occasional corner operands and backpressure.
        for (int i = 0; i < 40; i++) begin
            rid  = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            run_op(rid, ra, rb, rsub, $urandom_range(0, 2), model(rid, ra, rb, rsub), "rand");
        end

        apply_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
